// File: rtl/fp_wb_pkg.sv
// Shared types for the FP writeback scoreboard: register index, writeback
// request record and register-file geometry.
package fp_wb_pkg;

  localparam int NUM_FREGS = 32;
  localparam int WB_DATA_W = 32;

  typedef logic [4:0] freg_idx_t;

  typedef struct packed {
    freg_idx_t              frd;
    logic [WB_DATA_W-1:0]   data;
  } wb_req_t;

endpackage

// File: rtl/fp_wb_fifo.sv
// Small synchronous FIFO holding FPU results until they win the register-file
// write port. Push and pop may happen in the same cycle.
module fp_wb_fifo
  import fp_wb_pkg::*;
#(
  parameter type req_t = wb_req_t,
  parameter int  DEPTH = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push_i,
  input  req_t data_i,
  input  logic pop_i,
  output req_t data_o,
  output logic full_o,
  output logic empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  req_t             mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  // Storage carries no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  a_no_push_when_full : assert property (@(posedge clk_i) disable iff (!rst_ni)
    push_i |-> !full_o);

  a_no_pop_when_empty : assert property (@(posedge clk_i) disable iff (!rst_ni)
    pop_i |-> !empty_o);

endmodule

// File: rtl/fp_wb_scoreboard.sv
// FP writeback scoreboard: per-register pending-write tracking with RAW/WAW
// issue stall, and FPU/LSU arbitration onto the single register-file write port.
module fp_wb_scoreboard
  import fp_wb_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              issue_valid_i,
  input  logic              issue_wr_i,
  input  logic [4:0]        issue_frd_i,
  input  logic [14:0]       issue_frs_i,
  input  logic [2:0]        issue_rs_used_i,
  output logic              issue_stall_o,
  input  logic              fpu_valid_i,
  output logic              fpu_ready_o,
  input  logic [4:0]        fpu_frd_i,
  input  logic [DATA_W-1:0] fpu_data_i,
  input  logic              lsu_valid_i,
  output logic              lsu_ready_o,
  input  logic [4:0]        lsu_frd_i,
  input  logic [DATA_W-1:0] lsu_data_i,
  output logic              fregwrite_o,
  output logic [4:0]        frd_o,
  output logic [DATA_W-1:0] writeback_data_o,
  output logic [31:0]       busy_o
);

  // Handshakes: a result transfers on a cycle where valid and ready are both
  // high; ready never depends on valid of the same port, and a producer keeps
  // valid and payload stable until the transfer happens.

  typedef struct packed {
    freg_idx_t         frd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  localparam int SC_W = $clog2(STARVE_MAX + 1);

  logic [NUM_FREGS-1:0] busy_q;
  logic [NUM_FREGS-1:0] busy_d;
  logic [NUM_FREGS-1:0] set_mask;
  logic [NUM_FREGS-1:0] clr_mask;
  logic                 src_hit;
  logic                 issue_fire;

  wb_entry_t            fpu_entry;
  wb_entry_t            lsu_entry;
  wb_entry_t            fifo_head;
  wb_entry_t            win_entry;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 fifo_full;
  logic                 fifo_empty;

  logic [SC_W-1:0]      starve_q;
  logic [SC_W-1:0]      starve_d;
  logic                 force_head;
  logic                 lsu_win;
  logic                 win_valid;

  // ---------------- hazard detection ----------------
  always_comb begin
    src_hit = 1'b0;
    for (int s = 0; s < 3; s++) begin
      if (issue_rs_used_i[s] && busy_q[issue_frs_i[s*5 +: 5]]) begin
        src_hit = 1'b1;
      end
    end
  end

  assign issue_stall_o = issue_valid_i & (src_hit | (issue_wr_i & busy_q[issue_frd_i]));
  assign issue_fire    = issue_valid_i & ~issue_stall_o;

  // Clear tracks the write currently on the port; a set of the same bit wins.
  assign set_mask = (issue_fire & issue_wr_i) ? (NUM_FREGS'(1) << issue_frd_i) : '0;
  assign clr_mask = fregwrite_o ? (NUM_FREGS'(1) << frd_o) : '0;
  assign busy_d   = (busy_q & ~clr_mask) | set_mask;
  assign busy_o   = busy_q;

  // ---------------- FPU result buffer ----------------
  assign fpu_entry   = {fpu_frd_i, fpu_data_i};
  assign lsu_entry   = {lsu_frd_i, lsu_data_i};
  assign fpu_ready_o = ~fifo_full;
  assign fifo_push   = fpu_valid_i & fpu_ready_o;

  fp_wb_fifo #(
    .req_t (wb_entry_t),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (fifo_push),
    .data_i  (fpu_entry),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // ---------------- write-port arbitration ----------------
  always_comb begin
    force_head = (starve_q == SC_W'(STARVE_MAX)) & ~fifo_empty;
    fifo_pop   = force_head | (~lsu_valid_i & ~fifo_empty);
    lsu_win    = ~force_head & lsu_valid_i;
    win_valid  = fifo_pop | lsu_win;
    win_entry  = fifo_pop ? fifo_head : lsu_entry;
  end

  assign lsu_ready_o = ~force_head;

  // The counter measures how long a waiting FPU head has been passed over.
  always_comb begin
    starve_d = starve_q;
    if (fifo_pop || fifo_empty) begin
      starve_d = '0;
    end else if (lsu_win && (starve_q != SC_W'(STARVE_MAX))) begin
      starve_d = starve_q + SC_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q           <= '0;
      starve_q         <= '0;
      fregwrite_o      <= 1'b0;
      frd_o            <= '0;
      writeback_data_o <= '0;
    end else begin
      busy_q      <= busy_d;
      starve_q    <= starve_d;
      fregwrite_o <= win_valid;
      if (win_valid) begin
        frd_o            <= win_entry.frd;
        writeback_data_o <= win_entry.data;
      end
    end
  end

  // ---------------- protocol checks ----------------
  a_write_was_pending : assert property (@(posedge clk_i) disable iff (!rst_ni)
    fregwrite_o |-> busy_q[frd_o]);

  a_no_lsu_fpu_same_frd : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (lsu_valid_i && !fifo_empty) |-> (lsu_frd_i != fifo_head.frd));

endmodule

// File: tb/tb_fp_wb_scoreboard.sv
// Self-checking bench for fp_wb_scoreboard: directed hazard/arbitration cases
// plus randomized traffic, scored against a queue-based reference model.
module tb_fp_wb_scoreboard;

  localparam int DATA_W     = 32;
  localparam int FIFO_DEPTH = 2;
  localparam int STARVE_MAX = 4;
  localparam int EW         = 5 + DATA_W;

  logic              clk = 1'b0;
  logic              rst_ni = 1'b0;
  logic              issue_valid_i = 1'b0;
  logic              issue_wr_i = 1'b0;
  logic [4:0]        issue_frd_i = '0;
  logic [14:0]       issue_frs_i = '0;
  logic [2:0]        issue_rs_used_i = '0;
  logic              issue_stall_o;
  logic              fpu_valid_i = 1'b0;
  logic              fpu_ready_o;
  logic [4:0]        fpu_frd_i = '0;
  logic [DATA_W-1:0] fpu_data_i = '0;
  logic              lsu_valid_i = 1'b0;
  logic              lsu_ready_o;
  logic [4:0]        lsu_frd_i = '0;
  logic [DATA_W-1:0] lsu_data_i = '0;
  logic              fregwrite_o;
  logic [4:0]        frd_o;
  logic [DATA_W-1:0] writeback_data_o;
  logic [31:0]       busy_o;

  fp_wb_scoreboard #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_ni),
    .issue_valid_i    (issue_valid_i),
    .issue_wr_i       (issue_wr_i),
    .issue_frd_i      (issue_frd_i),
    .issue_frs_i      (issue_frs_i),
    .issue_rs_used_i  (issue_rs_used_i),
    .issue_stall_o    (issue_stall_o),
    .fpu_valid_i      (fpu_valid_i),
    .fpu_ready_o      (fpu_ready_o),
    .fpu_frd_i        (fpu_frd_i),
    .fpu_data_i       (fpu_data_i),
    .lsu_valid_i      (lsu_valid_i),
    .lsu_ready_o      (lsu_ready_o),
    .lsu_frd_i        (lsu_frd_i),
    .lsu_data_i       (lsu_data_i),
    .fregwrite_o      (fregwrite_o),
    .frd_o            (frd_o),
    .writeback_data_o (writeback_data_o),
    .busy_o           (busy_o)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int             n_total = 0;
  int             n_bad   = 0;
  logic [EW-1:0]  exp_q[$];
  logic [EW-1:0]  mon_e;

  // Reference model: FPU buffer as a queue, pending set as a bit vector.
  logic [EW-1:0]  m_fifo[$];
  logic [31:0]    m_busy = '0;
  int             m_starve = 0;
  bit             m_prev_v = 1'b0;
  logic [4:0]     m_prev_frd = '0;
  bit             m_fire, m_fpu_acc, m_lsu_acc;

  // Outstanding results owed by the random driver, split by source.
  logic [EW-1:0]  fpu_todo[$];
  logic [EW-1:0]  lsu_todo[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock of the reference model, evaluated on the inputs now applied.
  task automatic model_eval();
    int            sz;
    bit            src_hit, stall, frc, popped, win_v;
    logic [EW-1:0] win;
    sz      = m_fifo.size();
    src_hit = 1'b0;
    for (int s = 0; s < 3; s++) begin
      if (issue_rs_used_i[s] && m_busy[issue_frs_i[s*5 +: 5]]) src_hit = 1'b1;
    end
    stall = issue_valid_i && (src_hit || (issue_wr_i && m_busy[issue_frd_i]));
    frc   = (m_starve == STARVE_MAX) && (sz > 0);
    chk("issue_stall", issue_stall_o, stall);
    chk("fpu_ready", fpu_ready_o, sz < FIFO_DEPTH);
    chk("lsu_ready", lsu_ready_o, !frc);
    m_fire    = issue_valid_i && !stall;
    m_fpu_acc = fpu_valid_i && (sz < FIFO_DEPTH);
    m_lsu_acc = lsu_valid_i && !frc;
    popped = 1'b0;
    win_v  = 1'b0;
    win    = '0;
    if (frc || (!lsu_valid_i && sz > 0)) begin
      win    = m_fifo.pop_front();
      popped = 1'b1;
      win_v  = 1'b1;
    end else if (lsu_valid_i) begin
      win   = {lsu_frd_i, lsu_data_i};
      win_v = 1'b1;
    end
    if (popped || sz == 0) m_starve = 0;
    else if (lsu_valid_i && m_starve < STARVE_MAX) m_starve++;
    if (m_fpu_acc) m_fifo.push_back({fpu_frd_i, fpu_data_i});
    if (m_prev_v) m_busy[m_prev_frd] = 1'b0;
    if (m_fire && issue_wr_i) m_busy[issue_frd_i] = 1'b1;
    m_prev_v   = win_v;
    m_prev_frd = win[EW-1 -: 5];
    if (win_v) exp_q.push_back(win);
  endtask

  // Inputs are set at posedge+1; the model looks at them at posedge+3.
  task automatic tick();
    #2;
    model_eval();
    @(posedge clk);
    #1;
    chk("busy", busy_o, m_busy);
  endtask

  task automatic clear_inputs();
    issue_valid_i = 0; issue_wr_i = 0; issue_frd_i = '0; issue_frs_i = '0;
    issue_rs_used_i = '0; fpu_valid_i = 0; fpu_frd_i = '0; fpu_data_i = '0;
    lsu_valid_i = 0; lsu_frd_i = '0; lsu_data_i = '0;
  endtask

  task automatic do_reset(input string tag);
    rst_ni = 1'b0;
    clear_inputs();
    m_fifo.delete(); exp_q.delete(); fpu_todo.delete(); lsu_todo.delete();
    m_busy = '0; m_starve = 0; m_prev_v = 1'b0;
    #1;
    chk({tag, "_fregwrite"}, fregwrite_o, 0);
    chk({tag, "_frd"}, frd_o, 0);
    chk({tag, "_wdata"}, writeback_data_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_fpu_ready"}, fpu_ready_o, 1);
    chk({tag, "_lsu_ready"}, lsu_ready_o, 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic issue_wr(input logic [4:0] r);
    issue_valid_i = 1; issue_wr_i = 1; issue_frd_i = r; issue_rs_used_i = '0;
    tick();
    issue_valid_i = 0; issue_wr_i = 0;
  endtask

  task automatic lsu_one(input logic [4:0] r, input logic [DATA_W-1:0] d);
    lsu_valid_i = 1; lsu_frd_i = r; lsu_data_i = d;
    tick();
    lsu_valid_i = 0;
  endtask

  task automatic rand_cycle(input bit issue_en);
    logic [EW-1:0] e;
    issue_valid_i   = issue_en && ($urandom_range(0, 1) == 1);
    issue_wr_i      = ($urandom_range(0, 3) != 0);
    issue_frd_i     = 5'($urandom_range(0, 15));
    issue_frs_i     = {5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)), 5'($urandom_range(0, 15))};
    issue_rs_used_i = 3'($urandom_range(0, 7));
    if (!fpu_valid_i && fpu_todo.size() > 0 && $urandom_range(0, 2) != 0) begin
      fpu_valid_i = 1;
      {fpu_frd_i, fpu_data_i} = fpu_todo[0];
    end
    if (!lsu_valid_i && lsu_todo.size() > 0 && $urandom_range(0, 2) != 0) begin
      lsu_valid_i = 1;
      {lsu_frd_i, lsu_data_i} = lsu_todo[0];
    end
    tick();
    if (m_fpu_acc) begin void'(fpu_todo.pop_front()); fpu_valid_i = 0; end
    if (m_lsu_acc) begin void'(lsu_todo.pop_front()); lsu_valid_i = 0; end
    if (m_fire && issue_wr_i) begin
      e = {issue_frd_i, 32'($urandom)};
      if ($urandom_range(0, 1) == 1) fpu_todo.push_back(e);
      else lsu_todo.push_back(e);
    end
  endtask

  task automatic drain(input string tag, input int budget);
    int c;
    c = 0;
    while ((fpu_todo.size() > 0 || lsu_todo.size() > 0 || exp_q.size() > 0 ||
            fpu_valid_i || lsu_valid_i) && c < budget) begin
      rand_cycle(1'b0);
      c++;
    end
    chk({tag, "_timeout"}, (c >= budget), 0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_ni && fregwrite_o) begin
      if (exp_q.size() == 0) begin
        n_total++;
        n_bad++;
        $display("FAIL wb_unexpected: got frd=%0d data=%0h want no write (t=%0t)",
                 frd_o, writeback_data_o, $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wb_write", {frd_o, writeback_data_o}, mon_e);
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    int first_force;
    int lsu_idx;
    int fpu_i;

    do_reset("reset");

    // RAW on frd=5 resolved by an FPU result.
    issue_wr(5'd5);
    chk("raw_busy_set", busy_o[5], 1);
    issue_valid_i = 1; issue_wr_i = 0; issue_frs_i = 15'd5; issue_rs_used_i = 3'b001;
    #1;
    chk("raw_stall_hi", issue_stall_o, 1);
    tick();
    issue_valid_i = 0;
    fpu_valid_i = 1; fpu_frd_i = 5'd5; fpu_data_i = 32'h3F800000;
    tick();
    fpu_valid_i = 0;
    chk("raw_no_wb_n1", fregwrite_o, 0);
    tick();
    chk("raw_wb_n2", {fregwrite_o, frd_o, writeback_data_o}, {1'b1, 5'd5, 32'h3F800000});
    tick();
    chk("raw_busy_clr", busy_o[5], 0);
    issue_valid_i = 1; issue_frs_i = 15'd5; issue_rs_used_i = 3'b001;
    #1;
    chk("raw_stall_lo", issue_stall_o, 0);
    tick();
    issue_valid_i = 0; issue_rs_used_i = '0;

    // LSU and FPU results in the same cycle.
    issue_wr(5'd3);
    issue_wr(5'd4);
    lsu_valid_i = 1; lsu_frd_i = 5'd3; lsu_data_i = 32'h40000000;
    fpu_valid_i = 1; fpu_frd_i = 5'd4; fpu_data_i = 32'h40400000;
    tick();
    lsu_valid_i = 0; fpu_valid_i = 0;
    chk("coll_lsu_n1", {fregwrite_o, frd_o, writeback_data_o}, {1'b1, 5'd3, 32'h40000000});
    tick();
    chk("coll_fpu_n2", {fregwrite_o, frd_o, writeback_data_o}, {1'b1, 5'd4, 32'h40400000});
    tick();

    // Continuous LSU traffic starving two buffered FPU results.
    for (int r = 10; r < 20; r++) issue_wr(5'(r));
    lsu_idx = 10; fpu_i = 0; first_force = -1;
    for (int c = 0; c < 11; c++) begin
      lsu_valid_i = (lsu_idx <= 17);
      lsu_frd_i   = 5'(lsu_idx);
      lsu_data_i  = 32'h1000 + 32'(lsu_idx);
      fpu_valid_i = (fpu_i < 2);
      fpu_frd_i   = 5'(18 + fpu_i);
      fpu_data_i  = 32'h2000 + 32'(fpu_i);
      #1;
      if (c == 2) chk("starve_fpu_full", fpu_ready_o, 0);
      if (!lsu_ready_o && first_force < 0) first_force = c;
      tick();
      if (m_lsu_acc) lsu_idx++;
      if (m_fpu_acc) fpu_i++;
    end
    clear_inputs();
    chk("starve_force_cycle", first_force, 5);
    repeat (3) tick();

    // Issue of frd=7 presented while frd=7 is being written back.
    issue_wr(5'd7);
    lsu_one(5'd7, 32'h7777_0001);
    issue_valid_i = 1; issue_wr_i = 1; issue_frd_i = 5'd7;
    tick();
    tick();
    issue_valid_i = 0; issue_wr_i = 0;
    chk("setclr_busy7", busy_o[7], 1);
    lsu_one(5'd7, 32'h7777_0002);
    repeat (2) tick();

    // WAW: frd=9 re-issue waits for the pending write to commit.
    issue_wr(5'd9);
    issue_valid_i = 1; issue_wr_i = 1; issue_frd_i = 5'd9; issue_rs_used_i = '0;
    #1;
    chk("waw_stall", issue_stall_o, 1);
    repeat (3) tick();
    lsu_valid_i = 1; lsu_frd_i = 5'd9; lsu_data_i = 32'h9999_0001;
    tick();
    lsu_valid_i = 0;
    tick();
    tick();
    issue_valid_i = 0; issue_wr_i = 0;
    chk("waw_busy9", busy_o[9], 1);
    lsu_one(5'd9, 32'h9999_0002);
    repeat (2) tick();

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) rand_cycle(1'b1);
    clear_inputs();
    drain("rand_drain", 400);

    // Reset with two results sitting in the FPU buffer.
    for (int r = 20; r < 24; r++) issue_wr(5'(r));
    lsu_valid_i = 1; lsu_frd_i = 5'd20; lsu_data_i = 32'hA;
    fpu_valid_i = 1; fpu_frd_i = 5'd21; fpu_data_i = 32'hB;
    tick();
    lsu_frd_i = 5'd22; lsu_data_i = 32'hC;
    fpu_frd_i = 5'd23; fpu_data_i = 32'hD;
    tick();
    chk("midrst_fifo_full", fpu_ready_o, 0);
    do_reset("midrst");
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("midrst_no_write", fregwrite_o, 0);
    end

    chk("exp_q_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
